bp_mem_arbiter: RTL and testbench

- Shares one single-outstanding memory port (cmd, data_cmd, resp, data_resp channels) among num_cce_p CCEs.
- Picks requesters round-robin. Within one CCE, data_cmd (writeback) has priority over cmd (read).
- Registers the granted message toward memory and routes the memory response back to the owning CCE.
- Sits between the CCE array and the memory model/controller in the ME testbench and top level.

---
 rtl/bp_me_arb_pkg.sv | 17 +
 rtl/bp_mem_arb_rr_pick.sv | 31 +++
 rtl/bp_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_bp_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_arb_pkg.sv
// Shared types for the CCE-to-memory arbiter: FSM state encoding and a safe log2.
package bp_me_arb_pkg;

  typedef enum logic [2:0] {
    E_IDLE     = 3'd0,
    E_ISSUE_RD = 3'd1,
    E_ISSUE_WR = 3'd2,
    E_WAIT_RD  = 3'd3,
    E_WAIT_WR  = 3'd4
  } bp_mem_arb_state_e;

  // Index width that never collapses to zero for a single requester.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_mem_arb_rr_pick.sv
// Round-robin picker: first requester at or above ptr_i, wrapping modulo num_p.
module bp_mem_arb_rr_pick #(
  parameter int num_p    = 2,
  parameter int lg_num_p = 1
) (
  input  logic [num_p-1:0]    req_i,
  input  logic [lg_num_p-1:0] ptr_i,
  output logic [num_p-1:0]    grant_oh_o,
  output logic [lg_num_p-1:0] grant_idx_o,
  output logic                v_o
);

  // Scan num_p slots starting at ptr_i; the first hit wins.
  always_comb begin
    int idx;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    v_o         = 1'b0;
    idx         = 0;
    for (int k = 0; k < num_p; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= num_p) idx = idx - num_p;
      if (!v_o && req_i[idx]) begin
        v_o             = 1'b1;
        grant_oh_o[idx] = 1'b1;
        grant_idx_o     = lg_num_p'(idx);
      end
    end
  end

endmodule

// File: rtl/bp_mem_arbiter.sv
// Shares one single-outstanding memory port among num_cce_p CCEs, round-robin,
// writeback (data_cmd) ahead of read (cmd) within a CCE; responses are routed
// back to the owning CCE with zero latency.
module bp_mem_arbiter
  import bp_me_arb_pkg::*;
#(
  parameter int num_cce_p         = 2,
  parameter int cmd_width_p       = 64,
  parameter int data_cmd_width_p  = 64,
  parameter int resp_width_p      = 64,
  parameter int data_resp_width_p = 64,
  parameter int timeout_p         = 4096,
  parameter int lg_num_cce_lp     = safe_clog2(num_cce_p)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_cce_p*cmd_width_p-1:0]      cce_cmd_i,
  input  logic [num_cce_p-1:0]                  cce_cmd_v_i,
  output logic [num_cce_p-1:0]                  cce_cmd_yumi_o,
  input  logic [num_cce_p*data_cmd_width_p-1:0] cce_data_cmd_i,
  input  logic [num_cce_p-1:0]                  cce_data_cmd_v_i,
  output logic [num_cce_p-1:0]                  cce_data_cmd_yumi_o,
  output logic [resp_width_p-1:0]               cce_resp_o,
  output logic [num_cce_p-1:0]                  cce_resp_v_o,
  input  logic [num_cce_p-1:0]                  cce_resp_ready_i,
  output logic [data_resp_width_p-1:0]          cce_data_resp_o,
  output logic [num_cce_p-1:0]                  cce_data_resp_v_o,
  input  logic [num_cce_p-1:0]                  cce_data_resp_ready_i,
  output logic [cmd_width_p-1:0]                mem_cmd_o,
  output logic                                  mem_cmd_v_o,
  input  logic                                  mem_cmd_yumi_i,
  output logic [data_cmd_width_p-1:0]           mem_data_cmd_o,
  output logic                                  mem_data_cmd_v_o,
  input  logic                                  mem_data_cmd_yumi_i,
  input  logic [resp_width_p-1:0]               mem_resp_i,
  input  logic                                  mem_resp_v_i,
  output logic                                  mem_resp_ready_o,
  input  logic [data_resp_width_p-1:0]          mem_data_resp_i,
  input  logic                                  mem_data_resp_v_i,
  output logic                                  mem_data_resp_ready_o,
  output logic [lg_num_cce_lp-1:0]              owner_o,
  output logic                                  busy_o,
  output logic                                  timeout_o,
  output logic                                  proto_err_o
);

  localparam int cnt_w_lp = $clog2(timeout_p + 1);
  localparam logic [cnt_w_lp-1:0] to_lp = cnt_w_lp'(timeout_p);

  bp_mem_arb_state_e             state_q;
  logic [lg_num_cce_lp-1:0]      owner_q, rr_ptr_q, rr_next;
  logic [cmd_width_p-1:0]        cmd_q, cmd_sel;
  logic [data_cmd_width_p-1:0]   data_cmd_q, data_cmd_sel;
  logic [cnt_w_lp-1:0]           cnt_q, cnt_d;
  logic                          timeout_q, timeout_d;
  logic                          proto_err_q, proto_err_d;

  logic [num_cce_p-1:0]          req, grant_oh, owner_oh;
  logic [lg_num_cce_lp-1:0]      grant_idx;
  logic                          grant_v, grant, grant_wr, idle, wrong_ch;

  assign req  = cce_cmd_v_i | cce_data_cmd_v_i;
  assign idle = (state_q == E_IDLE);

  bp_mem_arb_rr_pick #(
    .num_p    (num_cce_p),
    .lg_num_p (lg_num_cce_lp)
  ) rr_pick (
    .req_i       (req),
    .ptr_i       (rr_ptr_q),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx),
    .v_o         (grant_v)
  );

  // Grant only from IDLE and never while reset is held.
  assign grant    = idle & grant_v & ~reset_i;
  assign grant_wr = |(grant_oh & cce_data_cmd_v_i);

  assign cce_data_cmd_yumi_o = (grant &  grant_wr) ? grant_oh : '0;
  assign cce_cmd_yumi_o      = (grant & ~grant_wr) ? grant_oh : '0;

  // With one requester this folds to a constant 0.
  assign rr_next = (grant_idx == lg_num_cce_lp'(num_cce_p - 1)) ? '0
                                                                : grant_idx + lg_num_cce_lp'(1);

  // Select the winner's payloads from the flattened request buses.
  always_comb begin
    cmd_sel      = '0;
    data_cmd_sel = '0;
    for (int i = 0; i < num_cce_p; i++) begin
      if (grant_oh[i]) begin
        cmd_sel      = cce_cmd_i[i*cmd_width_p +: cmd_width_p];
        data_cmd_sel = cce_data_cmd_i[i*data_cmd_width_p +: data_cmd_width_p];
      end
    end
  end

  // Decode the owner index into a one-hot response routing mask.
  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < num_cce_p; i++)
      owner_oh[i] = (owner_q == lg_num_cce_lp'(i));
  end

  // Flag responses arriving on the channel the current transaction cannot use.
  always_comb begin
    case (state_q)
      E_IDLE:                wrong_ch = mem_resp_v_i | mem_data_resp_v_i;
      E_ISSUE_RD, E_WAIT_RD: wrong_ch = mem_resp_v_i;
      default:               wrong_ch = mem_data_resp_v_i;
    endcase
  end

  // Wait counter saturates; timeout fires on the cycle it reaches timeout_p.
  always_comb begin
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    proto_err_d = proto_err_q | wrong_ch;
    if (grant) begin
      cnt_d = '0;
    end else if (!idle && cnt_q != to_lp) begin
      cnt_d = cnt_q + cnt_w_lp'(1);
      if (cnt_d == to_lp) timeout_d = 1'b1;
    end
  end

  // Arbitration FSM, hold registers and status flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= E_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      cmd_q       <= '0;
      data_cmd_q  <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
      case (state_q)
        E_IDLE: if (grant_v) begin
          owner_q  <= grant_idx;
          rr_ptr_q <= rr_next;
          if (grant_wr) begin
            data_cmd_q <= data_cmd_sel;
            state_q    <= E_ISSUE_WR;
          end else begin
            cmd_q   <= cmd_sel;
            state_q <= E_ISSUE_RD;
          end
        end
        E_ISSUE_RD: if (mem_cmd_yumi_i)      state_q <= E_WAIT_RD;
        E_ISSUE_WR: if (mem_data_cmd_yumi_i) state_q <= E_WAIT_WR;
        // Memory raises a response valid only while it sees ready.
        E_WAIT_RD:  if (mem_data_resp_v_i)   state_q <= E_IDLE;
        E_WAIT_WR:  if (mem_resp_v_i)        state_q <= E_IDLE;
        default:                             state_q <= E_IDLE;
      endcase
    end
  end

  assign mem_cmd_o        = cmd_q;
  assign mem_cmd_v_o      = (state_q == E_ISSUE_RD);
  assign mem_data_cmd_o   = data_cmd_q;
  assign mem_data_cmd_v_o = (state_q == E_ISSUE_WR);

  // Ready is live in ISSUE states too: memory checks it before taking a command.
  assign mem_resp_ready_o      = ~idle & |(cce_resp_ready_i & owner_oh);
  assign mem_data_resp_ready_o = ~idle & |(cce_data_resp_ready_i & owner_oh);

  assign cce_resp_o        = mem_resp_i;
  assign cce_data_resp_o   = mem_data_resp_i;
  assign cce_resp_v_o      = (~idle & mem_resp_v_i)      ? owner_oh : '0;
  assign cce_data_resp_v_o = (~idle & mem_data_resp_v_i) ? owner_oh : '0;

  assign owner_o     = owner_q;
  assign busy_o      = ~idle;
  assign timeout_o   = timeout_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_bp_mem_arbiter.sv
// Scoreboard bench for bp_mem_arbiter: two CCEs, a fixed-latency memory model.
module tb_bp_mem_arbiter;

  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i = 1'b1;
  logic [31:0]   cce_cmd_i = '0;
  logic [1:0]    cce_cmd_v_i = '0, cce_cmd_yumi_o;
  logic [47:0]   cce_data_cmd_i = '0;
  logic [1:0]    cce_data_cmd_v_i = '0, cce_data_cmd_yumi_o;
  logic [7:0]    cce_resp_o;
  logic [1:0]    cce_resp_v_o, cce_resp_ready_i = 2'b11;
  logic [11:0]   cce_data_resp_o;
  logic [1:0]    cce_data_resp_v_o, cce_data_resp_ready_i = 2'b11;
  logic [15:0]   mem_cmd_o;
  logic          mem_cmd_v_o, mem_cmd_yumi_i = 1'b0;
  logic [23:0]   mem_data_cmd_o;
  logic          mem_data_cmd_v_o, mem_data_cmd_yumi_i = 1'b0;
  logic [7:0]    mem_resp_i = '0;
  logic          mem_resp_v_i = 1'b0, mem_resp_ready_o;
  logic [11:0]   mem_data_resp_i = '0;
  logic          mem_data_resp_v_i = 1'b0, mem_data_resp_ready_o;
  logic          owner_o, busy_o, timeout_o, proto_err_o;

  bp_mem_arbiter #(
    .num_cce_p(N), .cmd_width_p(16), .data_cmd_width_p(24),
    .resp_width_p(8), .data_resp_width_p(12), .timeout_p(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cce_cmd_i(cce_cmd_i), .cce_cmd_v_i(cce_cmd_v_i), .cce_cmd_yumi_o(cce_cmd_yumi_o),
    .cce_data_cmd_i(cce_data_cmd_i), .cce_data_cmd_v_i(cce_data_cmd_v_i),
    .cce_data_cmd_yumi_o(cce_data_cmd_yumi_o),
    .cce_resp_o(cce_resp_o), .cce_resp_v_o(cce_resp_v_o), .cce_resp_ready_i(cce_resp_ready_i),
    .cce_data_resp_o(cce_data_resp_o), .cce_data_resp_v_o(cce_data_resp_v_o),
    .cce_data_resp_ready_i(cce_data_resp_ready_i),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
    .mem_data_cmd_o(mem_data_cmd_o), .mem_data_cmd_v_o(mem_data_cmd_v_o),
    .mem_data_cmd_yumi_i(mem_data_cmd_yumi_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
    .mem_data_resp_i(mem_data_resp_i), .mem_data_resp_v_i(mem_data_resp_v_i),
    .mem_data_resp_ready_o(mem_data_resp_ready_o),
    .owner_o(owner_o), .busy_o(busy_o), .timeout_o(timeout_o), .proto_err_o(proto_err_o)
  );

  typedef struct packed { logic wr; logic [1:0] oh; logic [15:0] pay; } exp_t;

  exp_t        expq[$];
  logic [15:0] cmdq0[$], cmdq1[$];
  logic [23:0] dcmdq0[$], dcmdq1[$];

  int nvec = 0, nerr = 0, dual = 0;
  logic rst = 1'b1, rdy0 = 1'b1, silent = 1'b0, inj = 1'b0;
  logic rd_pend = 1'b0, wr_pend = 1'b0;
  int dly = 0;
  logic [15:0] pay_cmd = '0;
  logic [23:0] pay_dcmd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] rd_xf(input logic [15:0] a);
    return a[15:4] ^ {a[3:0], 8'hA5};
  endfunction

  function automatic logic [7:0] wr_xf(input logic [23:0] d);
    return d[7:0] ^ d[15:8] ^ d[23:16] ^ 8'h3C;
  endfunction

  task automatic req_rd(input int c, input logic [15:0] a);
    exp_t e;
    if (c == 0) cmdq0.push_back(a); else cmdq1.push_back(a);
    e.wr = 1'b0; e.oh = (c == 0) ? 2'b01 : 2'b10; e.pay = {4'h0, rd_xf(a)};
    expq.push_back(e);
  endtask

  task automatic req_wr(input int c, input logic [23:0] d);
    exp_t e;
    if (c == 0) dcmdq0.push_back(d); else dcmdq1.push_back(d);
    e.wr = 1'b1; e.oh = (c == 0) ? 2'b01 : 2'b10; e.pay = {8'h0, wr_xf(d)};
    expq.push_back(e);
  endtask

  task automatic sb_pop(input logic wr, input logic [1:0] oh, input logic [15:0] pay);
    exp_t e;
    chk("sb_nonempty", expq.size() > 0, 1);
    if (expq.size() == 0) return;
    e = expq.pop_front();
    chk("rsp_channel", wr, e.wr);
    chk("rsp_owner", oh, e.oh);
    chk("rsp_payload", pay, e.pay);
  endtask

  // One clock: drive CCE side, then memory side, then monitor and book-keep.
  task automatic cyc();
    @(posedge clk); #1;
    reset_i          = rst;
    cce_cmd_v_i      = {cmdq1.size() != 0, cmdq0.size() != 0};
    cce_cmd_i        = {(cmdq1.size() != 0) ? cmdq1[0] : 16'h0,
                        (cmdq0.size() != 0) ? cmdq0[0] : 16'h0};
    cce_data_cmd_v_i = {dcmdq1.size() != 0, dcmdq0.size() != 0};
    cce_data_cmd_i   = {(dcmdq1.size() != 0) ? dcmdq1[0] : 24'h0,
                        (dcmdq0.size() != 0) ? dcmdq0[0] : 24'h0};
    cce_data_resp_ready_i = {1'b1, rdy0};
    cce_resp_ready_i      = 2'b11;
    mem_cmd_yumi_i        = mem_cmd_v_o;
    mem_data_cmd_yumi_i   = mem_data_cmd_v_o;
    #1;
    mem_data_resp_v_i = rd_pend && dly == 0 && !silent && mem_data_resp_ready_o;
    mem_data_resp_i   = rd_xf(pay_cmd);
    mem_resp_v_i      = inj || (wr_pend && dly == 0 && !silent && mem_resp_ready_o);
    mem_resp_i        = inj ? 8'hEE : wr_xf(pay_dcmd);
    #1;
    if (|cce_data_resp_v_o) sb_pop(1'b0, cce_data_resp_v_o, {4'h0, cce_data_resp_o});
    if (|cce_resp_v_o && !inj) sb_pop(1'b1, cce_resp_v_o, {8'h0, cce_resp_o});
    if ($countones({cce_cmd_yumi_o, cce_data_cmd_yumi_o}) > 1) dual++;
    if (cce_cmd_yumi_o[0])      void'(cmdq0.pop_front());
    if (cce_cmd_yumi_o[1])      void'(cmdq1.pop_front());
    if (cce_data_cmd_yumi_o[0]) void'(dcmdq0.pop_front());
    if (cce_data_cmd_yumi_o[1]) void'(dcmdq1.pop_front());
    if (mem_data_resp_v_i && mem_data_resp_ready_o) rd_pend = 1'b0;
    if (mem_resp_v_i && mem_resp_ready_o && !inj)   wr_pend = 1'b0;
    if (mem_cmd_v_o && mem_cmd_yumi_i) begin
      rd_pend = 1'b1; dly = 3; pay_cmd = mem_cmd_o;
    end else if (mem_data_cmd_v_o && mem_data_cmd_yumi_i) begin
      wr_pend = 1'b1; dly = 3; pay_dcmd = mem_data_cmd_o;
    end else if (dly > 0) begin
      dly--;
    end
    inj = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((expq.size() != 0 || busy_o || cmdq0.size() != 0 || cmdq1.size() != 0 ||
            dcmdq0.size() != 0 || dcmdq1.size() != 0) && n < maxc) begin
      cyc();
      n++;
    end
    chk("drain_in_budget", n < maxc, 1);
    chk("sb_left", expq.size(), 0);
  endtask

  initial begin
    // Reset holds every handshake low even with a request pending.
    req_rd(0, 16'h0040);
    cyc();
    chk("rst_cmd_yumi", cce_cmd_yumi_o, 2'b00);
    chk("rst_mem_cmd_v", mem_cmd_v_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_owner", owner_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_proto", proto_err_o, 0);
    chk("rst_dresp_ready", mem_data_resp_ready_o, 0);

    // Single read from CCE0: grant at 0, issue at 1, response at 5.
    rst = 1'b0;
    cyc();
    chk("t1_yumi_c0", cce_cmd_yumi_o, 2'b01);
    chk("t1_memv_c0", mem_cmd_v_o, 0);
    cyc();
    chk("t1_memv_c1", mem_cmd_v_o, 1);
    chk("t1_mem_cmd", mem_cmd_o, 16'h0040);
    chk("t1_owner", owner_o, 0);
    repeat (3) cyc();
    chk("t1_no_early_rsp", cce_data_resp_v_o, 2'b00);
    cyc();
    chk("t1_dresp_v_c5", cce_data_resp_v_o, 2'b01);
    cyc();
    chk("t1_idle_c6", busy_o, 0);

    // Both CCEs stream reads; rr_ptr is 1 after CCE0, so grants go 1,0,1,0.
    req_rd(1, 16'h1234); req_rd(0, 16'h5678); req_rd(1, 16'h9ABC); req_rd(0, 16'hDEF0);
    drain(100);
    chk("t2_single_yumi", dual, 0);

    // CCE1 with writeback and read pending: writeback wins, read follows.
    req_wr(1, 24'hABCDEF); req_rd(1, 16'h1111);
    cyc();
    chk("t3_wr_first", cce_data_cmd_yumi_o, 2'b10);
    chk("t3_no_rd_yumi", cce_cmd_yumi_o, 2'b00);
    drain(60);

    // Owner not ready: memory holds off until ready rises.
    rdy0 = 1'b0;
    req_rd(0, 16'h2468);
    cyc();
    repeat (6) cyc();
    chk("t4_ready_low", mem_data_resp_ready_o, 0);
    chk("t4_no_rsp", cce_data_resp_v_o, 2'b00);
    cyc();
    chk("t4_busy", busy_o, 1);
    rdy0 = 1'b1;
    cyc();
    chk("t4_rsp", cce_data_resp_v_o, 2'b01);
    cyc();
    chk("t4_done", busy_o, 0);
    chk("t4_no_timeout", timeout_o, 0);

    // Silent memory: timeout after 16 cycles, no grant while busy, then reset.
    silent = 1'b1;
    cmdq1.push_back(16'h0123);
    cyc();
    chk("t5_grant", cce_cmd_yumi_o, 2'b10);
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (k == 2) cmdq0.push_back(16'h0456);
      if (k == 16) begin
        chk("t5_timeout_pre", timeout_o, 0);
        chk("t5_no_grant_busy", cce_cmd_yumi_o, 2'b00);
      end
      if (k == 17) begin
        chk("t5_timeout", timeout_o, 1);
        chk("t5_busy", busy_o, 1);
        chk("t5_owner", owner_o, 1);
      end
    end
    rst = 1'b1;
    cyc();
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_timeout", timeout_o, 0);
    chk("t5_rst_owner", owner_o, 0);
    chk("t5_rst_yumi", cce_cmd_yumi_o, 2'b00);
    cmdq0.delete(); cmdq1.delete();
    rd_pend = 1'b0; wr_pend = 1'b0; dly = 0; silent = 1'b0;
    rst = 1'b0;
    cyc();
    chk("t5_idle_after", busy_o, 0);

    // Write response injected during WAIT_RD: flagged, forwarded, state held.
    req_rd(0, 16'h0F0F);
    repeat (3) cyc();
    chk("t6_proto_pre", proto_err_o, 0);
    inj = 1'b1;
    cyc();
    chk("t6_fwd", cce_resp_v_o, 2'b01);
    cyc();
    chk("t6_proto", proto_err_o, 1);
    chk("t6_busy", busy_o, 1);
    chk("t6_not_issue", mem_cmd_v_o, 0);
    drain(40);
    chk("t6_proto_sticky", proto_err_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
